fb_write_ctrl: RTL and testbench

- Sequences all writes into the 1-bit 320x200 framebuffer through the write port (port B) of the four 16 Kbit block RAMs; the read port stays owned by scan-out.
- Accepts PLOT and RECT-fill commands over a valid/ready handshake.
- Converts coordinates into a bank select and a 14-bit address, and issues one pixel write per cycle.
- Optionally restricts writes to blanking so scan-out never sees tearing.

---
 rtl/fb_pkg.sv | 32 +++
 rtl/fb_write_ctrl_addr_gen.sv | 96 +++++++++
 rtl/fb_write_ctrl.sv | 173 +++++++++++++++++
 tb/tb_fb_write_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Framebuffer write-side package: geometry, opcodes, controller states and
// a bank-select decode helper shared by the write controller and its
// address generator.
package fb_pkg;

  localparam int FB_WIDTH     = 320;
  localparam int FB_HEIGHT    = 200;
  localparam int FB_ADDR_BITS = 14;
  localparam int FB_BANK_BITS = 2;
  localparam int FB_IDX_BITS  = FB_ADDR_BITS + FB_BANK_BITS;
  localparam int FB_X_BITS    = 9;
  localparam int FB_Y_BITS    = 8;
  localparam int FB_BANKS     = 1 << FB_BANK_BITS;

  localparam logic OP_PLOT = 1'b0;
  localparam logic OP_RECT = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } fb_state_e;

  // One-hot decode of the bank field of a linear pixel index.
  function automatic logic [FB_BANKS-1:0] bank_onehot(input logic [FB_BANK_BITS-1:0] bank);
    logic [FB_BANKS-1:0] oh;
    oh = '0;
    oh[bank] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/fb_write_ctrl_addr_gen.sv
// Pixel address generator for rectangle fills.
// Owns the current pixel position (cur_x, cur_y) and the linear index
// idx = cur_y*WIDTH + cur_x. The multiply is done once at load; row
// advances afterwards are purely incremental.
// Ports:
//   clk_i, reset_i     clock and synchronous active-high reset
//   load_i             latch a new (validated) rectangle and seed idx
//   step_i             advance to the next pixel in row-major order
//   x0_i..y1_i         rectangle corners, inclusive (valid only with load_i)
//   idx_o              current linear pixel index
//   last_o             current pixel is the bottom-right corner
module fb_addr_gen
  import fb_pkg::*;
#(
  parameter int WIDTH = FB_WIDTH
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   load_i,
  input  logic                   step_i,
  input  logic [FB_X_BITS-1:0]   x0_i,
  input  logic [FB_Y_BITS-1:0]   y0_i,
  input  logic [FB_X_BITS-1:0]   x1_i,
  input  logic [FB_Y_BITS-1:0]   y1_i,
  output logic [FB_IDX_BITS-1:0] idx_o,
  output logic                   last_o
);

  localparam logic [FB_IDX_BITS-1:0] WIDTH_W = FB_IDX_BITS'(WIDTH);

  logic [FB_X_BITS-1:0]   x0_q, x0_d;
  logic [FB_X_BITS-1:0]   x1_q, x1_d;
  logic [FB_Y_BITS-1:0]   y1_q, y1_d;
  logic [FB_X_BITS-1:0]   cur_x_q, cur_x_d;
  logic [FB_Y_BITS-1:0]   cur_y_q, cur_y_d;
  logic [FB_IDX_BITS-1:0] idx_q, idx_d;
  // Distance from the last pixel of one row to the first of the next.
  logic [FB_IDX_BITS-1:0] row_adv_q, row_adv_d;

  // Next-state for position, index and the latched rectangle bounds.
  always_comb begin
    x0_d      = x0_q;
    x1_d      = x1_q;
    y1_d      = y1_q;
    cur_x_d   = cur_x_q;
    cur_y_d   = cur_y_q;
    idx_d     = idx_q;
    row_adv_d = row_adv_q;
    if (load_i) begin
      x0_d      = x0_i;
      x1_d      = x1_i;
      y1_d      = y1_i;
      cur_x_d   = x0_i;
      cur_y_d   = y0_i;
      idx_d     = ({{(FB_IDX_BITS-FB_Y_BITS){1'b0}}, y0_i} * WIDTH_W)
                + {{(FB_IDX_BITS-FB_X_BITS){1'b0}}, x0_i};
      row_adv_d = WIDTH_W - {{(FB_IDX_BITS-FB_X_BITS){1'b0}}, (x1_i - x0_i)};
    end else if (step_i) begin
      if (cur_x_q == x1_q) begin
        cur_x_d = x0_q;
        cur_y_d = cur_y_q + 8'd1;
        idx_d   = idx_q + row_adv_q;
      end else begin
        cur_x_d = cur_x_q + 9'd1;
        idx_d   = idx_q + 16'd1;
      end
    end else begin
      idx_d = idx_q;
    end
  end

  // Address generator state registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      x0_q      <= '0;
      x1_q      <= '0;
      y1_q      <= '0;
      cur_x_q   <= '0;
      cur_y_q   <= '0;
      idx_q     <= '0;
      row_adv_q <= '0;
    end else begin
      x0_q      <= x0_d;
      x1_q      <= x1_d;
      y1_q      <= y1_d;
      cur_x_q   <= cur_x_d;
      cur_y_q   <= cur_y_d;
      idx_q     <= idx_d;
      row_adv_q <= row_adv_d;
    end
  end

  assign idx_o  = idx_q;
  assign last_o = (cur_x_q == x1_q) && (cur_y_q == y1_q);

endmodule

// File: rtl/fb_write_ctrl.sv
// Framebuffer write controller.
// Accepts PLOT / RECT-fill commands over valid/ready, validates them,
// and drives the write port of the four banked block RAMs with one
// pixel write per cycle in row-major order. With BLANK_ONLY=1 writes are
// held off whenever scan-out is in the visible area.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   cmd_valid / cmd_ready      command handshake
//   cmd_op                     0 = PLOT (x0,y0), 1 = RECT (x0,y0)-(x1,y1)
//   cmd_x0..cmd_y1, cmd_color  command fields, latched on acceptance
//   vis_active                 scan-out visible-area flag (stall source)
//   ram_we, ram_addr, ram_din  one-hot bank write enable, address, data
//   busy, done, err            progress, completion pulse, reject pulse
module fb_write_ctrl
  import fb_pkg::*;
#(
  parameter int WIDTH      = FB_WIDTH,
  parameter int HEIGHT     = FB_HEIGHT,
  parameter bit BLANK_ONLY = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_op,
  input  logic [FB_X_BITS-1:0]    cmd_x0,
  input  logic [FB_Y_BITS-1:0]    cmd_y0,
  input  logic [FB_X_BITS-1:0]    cmd_x1,
  input  logic [FB_Y_BITS-1:0]    cmd_y1,
  input  logic                    cmd_color,
  input  logic                    vis_active,
  output logic [FB_BANKS-1:0]     ram_we,
  output logic [FB_ADDR_BITS-1:0] ram_addr,
  output logic                    ram_din,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam logic [FB_X_BITS:0] WIDTH_L  = (FB_X_BITS+1)'(WIDTH);
  localparam logic [FB_Y_BITS:0] HEIGHT_L = (FB_Y_BITS+1)'(HEIGHT);

  fb_state_e state_q, state_d;
  logic      color_q, color_d;
  logic      done_q, done_d;
  logic      err_q, err_d;

  logic                   accept_s;
  logic                   bad_s;
  logic                   stall_s;
  logic                   load_s;
  logic                   step_s;
  logic                   last_s;
  logic [FB_X_BITS-1:0]   x1_eff_s;
  logic [FB_Y_BITS-1:0]   y1_eff_s;
  logic [FB_IDX_BITS-1:0] idx_s;

  assign cmd_ready = (state_q == IDLE) && !reset;
  assign accept_s  = cmd_valid && cmd_ready;
  // vis_active is used combinationally so the write enable drops in the
  // very cycle scan-out enters the visible area.
  assign stall_s   = BLANK_ONLY && vis_active;

  // PLOT folds into a 1x1 rectangle; range and ordering checks on the fields.
  always_comb begin
    x1_eff_s = cmd_x1;
    y1_eff_s = cmd_y1;
    if (cmd_op == OP_PLOT) begin
      x1_eff_s = cmd_x0;
      y1_eff_s = cmd_y0;
    end else begin
      x1_eff_s = cmd_x1;
      y1_eff_s = cmd_y1;
    end
    bad_s = ({1'b0, cmd_x0}   >= WIDTH_L)
          | ({1'b0, x1_eff_s} >= WIDTH_L)
          | ({1'b0, cmd_y0}   >= HEIGHT_L)
          | ({1'b0, y1_eff_s} >= HEIGHT_L)
          | (cmd_x0 > x1_eff_s)
          | (cmd_y0 > y1_eff_s);
  end

  // Controller next-state, generator control and completion flags.
  always_comb begin
    state_d = state_q;
    color_d = color_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    load_s  = 1'b0;
    step_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          if (bad_s) begin
            // Rejected commands finish immediately and never leave IDLE.
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            state_d = WRITE;
            load_s  = 1'b1;
            color_d = cmd_color;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WRITE: begin
        if (stall_s) begin
          state_d = WRITE;
        end else if (last_s) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          step_s = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Controller state and registered status/data outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      color_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      color_q <= color_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  fb_addr_gen #(
    .WIDTH (WIDTH)
  ) u_addr_gen (
    .clk_i   (clk),
    .reset_i (reset),
    .load_i  (load_s),
    .step_i  (step_s),
    .x0_i    (cmd_x0),
    .y0_i    (cmd_y0),
    .x1_i    (x1_eff_s),
    .y1_i    (y1_eff_s),
    .idx_o   (idx_s),
    .last_o  (last_s)
  );

  // Write enable: one bank selected by the top index bits, only while
  // writing and not stalled.
  always_comb begin
    ram_we = '0;
    if ((state_q == WRITE) && !stall_s) begin
      ram_we = bank_onehot(idx_s[FB_IDX_BITS-1:FB_ADDR_BITS]);
    end else begin
      ram_we = '0;
    end
  end

  assign ram_addr = idx_s[FB_ADDR_BITS-1:0];
  assign ram_din  = color_q;
  assign busy     = (state_q == WRITE);
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_fb_write_ctrl.sv
// Self-checking bench for fb_write_ctrl (BLANK_ONLY=1 instance).
// Expected pixel writes are pushed to a scoreboard queue when a command
// is issued and compared in order against every observed RAM write.
module tb_fb_write_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_op = 1'b0;
  logic [8:0]  cmd_x0 = 9'd0;
  logic [7:0]  cmd_y0 = 8'd0;
  logic [8:0]  cmd_x1 = 9'd0;
  logic [7:0]  cmd_y1 = 8'd0;
  logic        cmd_color = 1'b0;
  logic        vis_active = 1'b0;
  logic [3:0]  ram_we;
  logic [13:0] ram_addr;
  logic        ram_din;
  logic        busy;
  logic        done;
  logic        err;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int wr_count = 0;
  bit vis_en   = 1'b0;

  logic [18:0] exp_q[$];

  fb_write_ctrl #(
    .WIDTH      (320),
    .HEIGHT     (200),
    .BLANK_ONLY (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_x0     (cmd_x0),
    .cmd_y0     (cmd_y0),
    .cmd_x1     (cmd_x1),
    .cmd_y1     (cmd_y1),
    .cmd_color  (cmd_color),
    .vis_active (vis_active),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Edge counter used for latency checks.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: row-major pixel order, index = y*320+x.
  task automatic push_rect(input int x0, input int y0, input int x1, input int y1, input logic c);
    for (int y = y0; y <= y1; y++) begin
      for (int x = x0; x <= x1; x++) begin
        logic [15:0] ix;
        ix = 16'(y * 320 + x);
        exp_q.push_back({4'b0001 << ix[15:14], ix[13:0], c});
      end
    end
  endtask

  // Write monitor: samples mid-cycle, checks stall rule and scoreboard.
  always @(negedge clk) begin
    #2;
    if (vis_active) chk("we_during_vis", {28'd0, ram_we}, 32'd0);
    if (ram_we !== 4'b0000) begin
      if (exp_q.size() == 0) begin
        chk("extra_write", {13'd0, ram_we, ram_addr, ram_din}, 32'd0);
      end else begin
        chk("write", {13'd0, ram_we, ram_addr, ram_din}, {13'd0, exp_q.pop_front()});
      end
      wr_count++;
    end
  end

  // Visible-area stimulus: occasional single-cycle visible periods.
  initial begin
    forever begin
      @(negedge clk);
      vis_active = vis_en ? ($urandom_range(0, 15) == 0) : 1'b0;
    end
  end

  // Issue one command and follow it to its done pulse.
  task automatic run_cmd(input logic op, input int x0, input int y0, input int x1, input int y1,
                         input logic color, input logic exp_err, input int npix, input bit timed);
    int  ta;
    int  base;
    bit  got_done;
    @(negedge clk);
    #3;
    chk("ready_before", {31'd0, cmd_ready}, 32'd1);
    cmd_op    = op;
    cmd_x0    = 9'(x0);
    cmd_y0    = 8'(y0);
    cmd_x1    = 9'(x1);
    cmd_y1    = 8'(y1);
    cmd_color = color;
    cmd_valid = 1'b1;
    if (!exp_err) begin
      if (op) push_rect(x0, y0, x1, y1, color);
      else    push_rect(x0, y0, x0, y0, color);
    end
    base = wr_count;
    @(negedge clk);
    ta = cyc;
    // Fields change after acceptance; the DUT must ignore them.
    cmd_valid = 1'b0;
    cmd_x0    = 9'd7;
    cmd_y0    = 8'd3;
    cmd_x1    = 9'd300;
    cmd_y1    = 8'd150;
    cmd_color = ~color;
    got_done  = 1'b0;
    for (int w = 0; w < npix * 3 + 20; w++) begin
      #3;
      if (done) begin
        got_done = 1'b1;
        if (timed) chk("done_cycle", 32'(cyc), 32'(ta + npix));
        chk("err", {31'd0, err}, {31'd0, exp_err});
        chk("write_count", 32'(wr_count - base), 32'(npix));
        if (exp_err) chk("ready_at_reject", {31'd0, cmd_ready}, 32'd1);
        break;
      end
      if (timed) chk("busy", {31'd0, busy}, {31'd0, (cyc < ta + npix)});
      @(negedge clk);
    end
    chk("done_seen", {31'd0, got_done}, 32'd1);
    @(negedge clk);
    #3;
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("ready_after", {31'd0, cmd_ready}, 32'd1);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int base;
    bit hit;
    // Reset state.
    repeat (3) @(negedge clk);
    #3;
    chk("rst_we", {28'd0, ram_we}, 32'd0);
    chk("rst_addr", {18'd0, ram_addr}, 32'd0);
    chk("rst_din", {31'd0, ram_din}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_ready", {31'd0, cmd_ready}, 32'd0);
    reset = 1'b0;

    // Directed commands, no stalls. PLOT x1/y1 are garbage on purpose.
    run_cmd(1'b0, 0,   0,   5,   0,   1'b1, 1'b0, 1,   1'b1);
    run_cmd(1'b0, 319, 199, 0,   0,   1'b1, 1'b0, 1,   1'b1);
    run_cmd(1'b1, 2,   1,   4,   2,   1'b0, 1'b0, 6,   1'b1);
    run_cmd(1'b1, 63,  51,  64,  51,  1'b1, 1'b0, 2,   1'b1);
    run_cmd(1'b1, 320, 0,   320, 0,   1'b1, 1'b1, 0,   1'b1);
    run_cmd(1'b1, 5,   0,   4,   0,   1'b1, 1'b1, 0,   1'b1);
    run_cmd(1'b0, 10,  200, 10,  200, 1'b1, 1'b1, 0,   1'b1);
    run_cmd(1'b1, 10,  5,   10,  200, 1'b1, 1'b1, 0,   1'b1);
    run_cmd(1'b1, 300, 190, 319, 199, 1'b1, 1'b0, 200, 1'b1);

    // Full-screen fill with scan-out stalls.
    vis_en = 1'b1;
    run_cmd(1'b1, 0, 0, 319, 199, 1'b1, 1'b0, 64000, 1'b0);

    // Full-screen fill abandoned by reset after 1000 writes.
    @(negedge clk);
    #3;
    cmd_op = 1'b1; cmd_x0 = 9'd0; cmd_y0 = 8'd0; cmd_x1 = 9'd319; cmd_y1 = 8'd199;
    cmd_color = 1'b0;
    cmd_valid = 1'b1;
    push_rect(0, 0, 319, 199, 1'b0);
    base = wr_count;
    @(negedge clk);
    cmd_valid = 1'b0;
    hit = 1'b0;
    for (int w = 0; w < 3000; w++) begin
      #3;
      if (wr_count - base >= 1000) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("reached_1000", {31'd0, hit}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    #3;
    chk("rst_mid_we", {28'd0, ram_we}, 32'd0);
    chk("rst_mid_done", {31'd0, done}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_ready", {31'd0, cmd_ready}, 32'd0);
    exp_q.delete();
    reset = 1'b0;
    #1;
    chk("ready_after_rst", {31'd0, cmd_ready}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #3;
      chk("no_done_after_rst", {31'd0, done}, 32'd0);
      chk("no_we_after_rst", {28'd0, ram_we}, 32'd0);
    end
    vis_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
